// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin recorder/player arbiter for an asynchronous 16-bit SRAM
module sram_arbiter #(
  parameter int unsigned WAIT_CYC = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_rec_req,
  input  logic [19:0] i_rec_addr,
  input  logic [15:0] i_rec_data,
  output logic        o_rec_ack,
  input  logic        i_ply_req,
  input  logic [19:0] i_ply_addr,
  output logic [15:0] o_ply_data,
  output logic        o_ply_ack,
  output logic [19:0] o_SRAM_ADDR,
  inout  wire  [15:0] io_SRAM_DQ,
  output logic        o_SRAM_WE_N,
  output logic        o_SRAM_CE_N,
  output logic        o_SRAM_OE_N,
  output logic        o_SRAM_LB_N,
  output logic        o_SRAM_UB_N,
  output logic        o_busy
);
  typedef enum logic [1:0] {IDLE, WR, RD, ACK} state_t;
  localparam logic [2:0] WAIT_LD = 3'(WAIT_CYC);
  state_t      state_q;
  logic [2:0]  cnt_q;
  logic        last_ply_q;
  logic [19:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] ply_data_q;
  logic        rec_ack_q;
  logic        ply_ack_q;
  logic        we_n_q;
  logic        oe_n_q;
  logic        en_n_q;
  logic        dq_oe_q;
  logic        busy_q;
  logic        grant_any_d;
  logic        grant_rec_d;
  // recorder wins when alone, or on a tie when the player was served last
  always_comb begin
    grant_any_d = i_rec_req | i_ply_req;
    grant_rec_d = i_rec_req & (~i_ply_req | last_ply_q);
  end
  // arbiter FSM; every SRAM strobe, ack and data output is a register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_ply_q <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      ply_data_q <= '0;
      rec_ack_q  <= 1'b0;
      ply_ack_q  <= 1'b0;
      we_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      en_n_q     <= 1'b1;
      dq_oe_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      en_n_q    <= 1'b0;
      rec_ack_q <= 1'b0;
      ply_ack_q <= 1'b0;
      case (state_q)
        IDLE: if (grant_any_d) begin
          busy_q     <= 1'b1;
          cnt_q      <= WAIT_LD;
          last_ply_q <= ~grant_rec_d;
          addr_q     <= grant_rec_d ? i_rec_addr : i_ply_addr;
          if (grant_rec_d) begin
            state_q <= WR;
            wdata_q <= i_rec_data;
            we_n_q  <= 1'b0;
            dq_oe_q <= 1'b1;
          end else begin
            state_q <= RD;
            oe_n_q  <= 1'b0;
          end
        end
        WR: if (cnt_q == 3'd0) begin
          state_q   <= ACK;
          we_n_q    <= 1'b1;
          dq_oe_q   <= 1'b0;
          rec_ack_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q - 3'd1;
        end
        RD: if (cnt_q == 3'd0) begin
          state_q    <= ACK;
          oe_n_q     <= 1'b1;
          ply_data_q <= io_SRAM_DQ;
          ply_ack_q  <= 1'b1;
        end else begin
          cnt_q <= cnt_q - 3'd1;
        end
        ACK: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
  assign io_SRAM_DQ  = dq_oe_q ? wdata_q : 16'hzzzz;
  assign o_SRAM_ADDR = addr_q;
  assign o_SRAM_WE_N = we_n_q;
  assign o_SRAM_OE_N = oe_n_q;
  assign o_SRAM_CE_N = en_n_q;
  assign o_SRAM_LB_N = en_n_q;
  assign o_SRAM_UB_N = en_n_q;
  assign o_rec_ack   = rec_ack_q;
  assign o_ply_ack   = ply_ack_q;
  assign o_ply_data  = ply_data_q;
  assign o_busy      = busy_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed bench for sram_arbiter with a small SRAM model
module tb_sram_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        rec_req, ply_req, probe_en;
  logic [19:0] rec_addr, ply_addr;
  logic [15:0] rec_data;
  logic        rec_ack, ply_ack, we_n, ce_n, oe_n, lb_n, ub_n, busy;
  logic [15:0] ply_data;
  logic [19:0] addr;
  tri   [15:0] dq;
  logic [15:0] mem [64] = '{default: 16'h0000};
  logic [1:0]  req_w, we_w, ack_w, pack_w, ce_w, oe_w, lb_w, ub_w, bz_w;
  logic [15:0] pd_w0, pd_w1;
  logic [19:0] ad_w0, ad_w1;
  tri   [15:0] dq_w0, dq_w1;
  int          vec = 0;
  int          errs = 0;
  always #5 clk = ~clk;
  sram_arbiter #(.WAIT_CYC(1)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rec_req(rec_req), .i_rec_addr(rec_addr), .i_rec_data(rec_data), .o_rec_ack(rec_ack),
    .i_ply_req(ply_req), .i_ply_addr(ply_addr), .o_ply_data(ply_data), .o_ply_ack(ply_ack),
    .o_SRAM_ADDR(addr), .io_SRAM_DQ(dq), .o_SRAM_WE_N(we_n), .o_SRAM_CE_N(ce_n),
    .o_SRAM_OE_N(oe_n), .o_SRAM_LB_N(lb_n), .o_SRAM_UB_N(ub_n), .o_busy(busy)
  );
  sram_arbiter #(.WAIT_CYC(0)) u_w0 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rec_req(req_w[0]), .i_rec_addr(rec_addr), .i_rec_data(rec_data), .o_rec_ack(ack_w[0]),
    .i_ply_req(1'b0), .i_ply_addr(20'h0), .o_ply_data(pd_w0), .o_ply_ack(pack_w[0]),
    .o_SRAM_ADDR(ad_w0), .io_SRAM_DQ(dq_w0), .o_SRAM_WE_N(we_w[0]), .o_SRAM_CE_N(ce_w[0]),
    .o_SRAM_OE_N(oe_w[0]), .o_SRAM_LB_N(lb_w[0]), .o_SRAM_UB_N(ub_w[0]), .o_busy(bz_w[0])
  );
  sram_arbiter #(.WAIT_CYC(7)) u_w7 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rec_req(req_w[1]), .i_rec_addr(rec_addr), .i_rec_data(rec_data), .o_rec_ack(ack_w[1]),
    .i_ply_req(1'b0), .i_ply_addr(20'h0), .o_ply_data(pd_w1), .o_ply_ack(pack_w[1]),
    .o_SRAM_ADDR(ad_w1), .io_SRAM_DQ(dq_w1), .o_SRAM_WE_N(we_w[1]), .o_SRAM_CE_N(ce_w[1]),
    .o_SRAM_OE_N(oe_w[1]), .o_SRAM_LB_N(lb_w[1]), .o_SRAM_UB_N(ub_w[1]), .o_busy(bz_w[1])
  );
  // SRAM model drives on OE_N; probe drives zeros so any DUT drive shows up as nonzero bits
  assign dq = (!oe_n && !ce_n) ? mem[addr[5:0]] : 16'hzzzz;
  assign dq = probe_en ? 16'h0000 : 16'hzzzz;
  always @(posedge clk) if (!we_n && !ce_n) mem[addr[5:0]] <= dq;
  // write and read strobes must never overlap
  always @(negedge clk) if (rst_n) begin
    vec++;
    assert (we_n | oe_n) else begin
      errs++;
      $error("FAIL excl_strobe: observed we_n=%b oe_n=%b expected not both 0", we_n, oe_n);
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_released(input string tag);
    probe_en = 1'b1;
    #1;
    chk(tag, 32'(dq), 32'h0);
    probe_en = 1'b0;
  endtask
  initial begin
    int       gt [4];
    logic     gr [4];
    int       ng, wc, width, n;
    logic     prev, seen;
    rst_n = 1'b0; rec_req = 1'b0; ply_req = 1'b0; probe_en = 1'b0; req_w = 2'b00;
    rec_addr = '0; rec_data = '0; ply_addr = '0;
    gt = '{default: 0}; gr = '{default: 1'b0};
    tick; tick;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_we_n", 32'(we_n), 1);
    chk("rst_oe_n", 32'(oe_n), 1);
    chk("rst_ce_lb_ub", {29'h0, ce_n, lb_n, ub_n}, 32'h7);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_ply_data", 32'(ply_data), 0);
    chk("rst_acks", {30'h0, rec_ack, ply_ack}, 0);
    chk_released("rst_dq");
    rst_n = 1'b1;
    tick;
    chk("run_ce_lb_ub", {29'h0, ce_n, lb_n, ub_n}, 0);
    chk("run_idle_busy", 32'(busy), 0);
    // seed 0x1234 at 0x00020 through the DUT
    rec_addr = 20'h00020; rec_data = 16'h1234; rec_req = 1'b1;
    tick; tick; tick;
    chk("seed_ack", 32'(rec_ack), 1);
    rec_req = 1'b0;
    tick;
    // single write: WE_N low for 2 samples, ack on the third, later input changes ignored
    rec_addr = 20'h00010; rec_data = 16'hA5A5; rec_req = 1'b1;
    tick;
    chk("w_we_n0", 32'(we_n), 0);
    chk("w_addr0", 32'(addr), 32'h10);
    chk("w_dq0", 32'(dq), 32'hA5A5);
    chk("w_busy", 32'(busy), 1);
    rec_req = 1'b0; rec_addr = 20'h77777; rec_data = 16'h0000;
    tick;
    chk("w_we_n1", 32'(we_n), 0);
    chk("w_addr1", 32'(addr), 32'h10);
    chk("w_dq1", 32'(dq), 32'hA5A5);
    chk("w_ack_early", 32'(rec_ack), 0);
    tick;
    chk("w_we_n_end", 32'(we_n), 1);
    chk("w_ack", 32'(rec_ack), 1);
    chk_released("w_dq_ack");
    tick;
    chk("w_ack_pulse", 32'(rec_ack), 0);
    chk("w_idle", 32'(busy), 0);
    chk("w_addr_hold", 32'(addr), 32'h10);
    chk_released("w_dq_idle");
    // single read of 0x00020
    ply_addr = 20'h00020; ply_req = 1'b1;
    tick;
    chk("r_oe_n0", 32'(oe_n), 0);
    chk("r_we_n0", 32'(we_n), 1);
    chk("r_addr", 32'(addr), 32'h20);
    tick;
    chk("r_oe_n1", 32'(oe_n), 0);
    chk("r_ack_early", 32'(ply_ack), 0);
    tick;
    chk("r_oe_n_end", 32'(oe_n), 1);
    chk("r_ack", 32'(ply_ack), 1);
    chk("r_data", 32'(ply_data), 32'h1234);
    ply_req = 1'b0;
    tick;
    chk("r_ack_pulse", 32'(ply_ack), 0);
    chk("r_data_hold", 32'(ply_data), 32'h1234);
    chk("r_idle", 32'(busy), 0);
    // reset clears read data; then simultaneous requests alternate starting with the recorder
    rst_n = 1'b0;
    tick;
    chk("rr_rst_data", 32'(ply_data), 0);
    rst_n = 1'b1;
    rec_addr = 20'h00030; rec_data = 16'h4321; ply_addr = 20'h00020;
    rec_req = 1'b1; ply_req = 1'b1;
    prev = busy; ng = 0;
    for (int c = 1; c <= 16; c++) begin
      tick;
      if (busy && !prev && ng < 4) begin
        gt[ng] = c;
        gr[ng] = ~we_n;
        ng++;
      end
      prev = busy;
    end
    rec_req = 1'b0; ply_req = 1'b0;
    tick;
    chk("rr_grants", 32'(ng), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr_is_rec%0d", i), 32'(gr[i]), 32'(i % 2 == 0));
      chk($sformatf("rr_edge%0d", i), 32'(gt[i]), 32'(1 + 4 * i));
    end
    chk("rr_last_data", 32'(ply_data), 32'h1234);
    tick; tick;
    // reset during the second write cycle aborts the access
    rec_addr = 20'h00123; rec_data = 16'hBEEF; rec_req = 1'b1;
    tick;
    chk("ab_we_n0", 32'(we_n), 0);
    rec_req = 1'b0;
    tick;
    chk("ab_we_n1", 32'(we_n), 0);
    rst_n = 1'b0;
    tick;
    chk("ab_we_n", 32'(we_n), 1);
    chk("ab_busy", 32'(busy), 0);
    chk("ab_ack", 32'(rec_ack), 0);
    chk("ab_data", 32'(ply_data), 0);
    chk_released("ab_dq");
    rst_n = 1'b1;
    tick;
    chk("ab_no_ack", 32'(rec_ack), 0);
    chk("ab_idle", 32'(busy), 0);
    // extreme addresses and data
    rec_addr = 20'hFFFFF; rec_data = 16'hFFFF; rec_req = 1'b1;
    tick;
    chk("b_addr_max", 32'(addr), 32'hFFFFF);
    chk("b_dq_max", 32'(dq), 32'hFFFF);
    rec_req = 1'b0;
    tick; tick;
    chk("b_ack_max", 32'(rec_ack), 1);
    tick;
    rec_addr = 20'h00000; rec_data = 16'h0000; rec_req = 1'b1;
    tick;
    chk("b_addr_min", 32'(addr), 0);
    chk("b_dq_min", 32'(dq), 0);
    rec_req = 1'b0;
    tick; tick; tick;
    ply_addr = 20'hFFFFF; ply_req = 1'b1;
    tick;
    chk("b_raddr_max", 32'(addr), 32'hFFFFF);
    tick; tick;
    chk("b_rack_max", 32'(ply_ack), 1);
    chk("b_rdata_max", 32'(ply_data), 32'hFFFF);
    ply_req = 1'b0;
    tick;
    // WAIT_CYC sweep: strobe width WAIT_CYC+1, ack seen by the edge WAIT_CYC+2 after the grant
    for (int k = 0; k < 2; k++) begin
      wc = (k == 0) ? 0 : 7;
      width = 0; n = 0; seen = 1'b0;
      req_w[k] = 1'b1;
      tick;
      req_w[k] = 1'b0;
      while (!seen && n < 20) begin
        if (!we_w[k]) width++;
        if (ack_w[k]) seen = 1'b1;
        else begin
          tick;
          n++;
        end
      end
      chk($sformatf("sw%0d_ack_seen", wc), 32'(seen), 1);
      chk($sformatf("sw%0d_width", wc), 32'(width), 32'(wc + 1));
      chk($sformatf("sw%0d_latency", wc), 32'(n + 1), 32'(wc + 2));
      tick;
      chk($sformatf("sw%0d_ack_pulse", wc), 32'(ack_w[k]), 0);
      tick;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
